key_debounce: RTL and testbench

//   Debounces one active-low mechanical push-button and emits a single-cycle press pulse.

---
 rtl/key_debounce_pkg.sv | 31 +++
 rtl/key_debounce_if.sv | 14 +
 rtl/key_debounce_sync_2ff.sv | 26 ++
 rtl/key_debounce.sv | 142 ++++++++++++++
 tb/tb_key_debounce.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/key_debounce_pkg.sv
// Shared types and constants for the push-button debouncer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: FSM state encoding, default timing constants, counter-width helper.
package key_debounce_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESS_F = 2'd1,
      DOWN    = 2'd2,
      REL_F   = 2'd3
   } state_t;

   // Defaults for a 50 MHz clock: 20 ms filter, 500 ms first repeat, 200 ms repeat rate.
   localparam int unsigned CNT_MAX_DEF    = 999_999;
   localparam int unsigned LONG_MAX_DEF   = 24_999_999;
   localparam int unsigned REPEAT_MAX_DEF = 9_999_999;

   // Bits needed to hold the largest of the three terminal counts.
   function automatic int cnt_width(int unsigned a, int unsigned b, int unsigned c);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return (m == 0) ? 1 : $clog2(m + 1);
   endfunction

   localparam int CNT_W = cnt_width(CNT_MAX_DEF, LONG_MAX_DEF, REPEAT_MAX_DEF);

endpackage

// File: rtl/key_debounce_if.sv
// Button-side signal bundle: raw key input plus debounced pulse/level outputs.
// Latency: n/a (wires only).
// Backpressure: none; key_flag is a fire-and-forget pulse.
//
// master : drives key_in, observes key_flag/key_level (button + consumer side)
// slave  : the debouncer
interface key_debounce_if;
   logic key_in;     // raw button, active-low, asynchronous
   logic key_flag;   // one-cycle pulse per accepted press / repeat
   logic key_level;  // debounced level, 1 = pressed

   modport master (output key_in,  input  key_flag, input key_level);
   modport slave  (input  key_in,  output key_flag, output key_level);
endinterface

// File: rtl/key_debounce_sync_2ff.sv
// Two-flop synchroniser for an asynchronous, active-low button input.
// Latency: 2 cycles.
// Backpressure: none.
//
// Ports: clk_i, rst_ni (async active-low), d_i (async in), q_o (synchronised out).
// Resets to 1 so a released button is the power-up value.
module sync_2ff (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   logic [1:0] sync_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], d_i};
      end
   end

   assign q_o = sync_q[1];

endmodule

// File: rtl/key_debounce.sv
// Debounces one active-low push-button; emits a one-cycle press pulse and a debounced level.
// Latency: key_flag 2 + CNT_MAX + 1 cycles after a clean fall of key_in.
// Backpressure: none; key_flag is a registered single-cycle pulse.
//
// Ports: sys_clk, sys_rst_n (async active-low), key_if (slave: key_in in, key_flag/key_level out).
// Optional feature: define KEY_REPEAT_EN for auto-repeat pulses while the key is held.
module key_debounce
   import key_debounce_pkg::*;
#(
   parameter int unsigned CNT_MAX    = CNT_MAX_DEF,
   parameter int unsigned LONG_MAX   = LONG_MAX_DEF,
   parameter int unsigned REPEAT_MAX = REPEAT_MAX_DEF
) (
   input  logic           sys_clk,
   input  logic           sys_rst_n,
   key_debounce_if.slave  key_if
);

   localparam int CW = cnt_width(CNT_MAX, LONG_MAX, REPEAT_MAX);
   localparam logic [CW-1:0] CNT_LIM = CW'(CNT_MAX);

   logic          key_s;
   state_t        state_q;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_inc_d;
   logic          flag_q;
   logic          level_q;
   // boot_q marks when the synchroniser holds real samples again after reset;
   // arm_q then requires one released observation before any press is accepted,
   // so a key held through reset never produces a pulse.
   logic [1:0]    boot_q;
   logic          arm_q;

   sync_2ff u_sync (
      .clk_i  (sys_clk),
      .rst_ni (sys_rst_n),
      .d_i    (key_if.key_in),
      .q_o    (key_s)
   );

   // Saturating increment: the counter never wraps.
   assign cnt_inc_d = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CW'(1);

`ifdef KEY_REPEAT_EN
   localparam logic [CW-1:0] LONG_LIM = CW'(LONG_MAX);
   localparam logic [CW-1:0] REP_LIM  = CW'(REPEAT_MAX);

   logic [CW-1:0] hold_cnt_q;
   logic [CW-1:0] hold_inc_d;
   logic          rep_q;     // first long-hold pulse already issued

   assign hold_inc_d = (hold_cnt_q == {CW{1'b1}}) ? hold_cnt_q : hold_cnt_q + CW'(1);
`endif

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         flag_q     <= 1'b0;
         level_q    <= 1'b0;
         boot_q     <= 2'b00;
         arm_q      <= 1'b0;
`ifdef KEY_REPEAT_EN
         hold_cnt_q <= '0;
         rep_q      <= 1'b0;
`endif
      end else begin
         flag_q <= 1'b0;
         boot_q <= {boot_q[0], 1'b1};
         if (boot_q[1] && key_s) begin
            arm_q <= 1'b1;
         end

         case (state_q)
            IDLE: begin
               if (arm_q && !key_s) begin
                  state_q <= PRESS_F;
                  cnt_q   <= '0;
               end
            end

            PRESS_F: begin
               if (key_s) begin
                  state_q <= IDLE;            // bounce rejected
               end else if (cnt_q == CNT_LIM) begin
                  state_q <= DOWN;
                  flag_q  <= 1'b1;
                  level_q <= 1'b1;
`ifdef KEY_REPEAT_EN
                  hold_cnt_q <= '0;
                  rep_q      <= 1'b0;
`endif
               end else begin
                  cnt_q <= cnt_inc_d;
               end
            end

            DOWN: begin
               // Release has priority over a repeat pulse due in the same cycle.
               if (key_s) begin
                  state_q <= REL_F;
                  cnt_q   <= '0;
`ifdef KEY_REPEAT_EN
                  hold_cnt_q <= '0;
                  rep_q      <= 1'b0;
`endif
               end
`ifdef KEY_REPEAT_EN
               else if (hold_cnt_q == (rep_q ? REP_LIM : LONG_LIM)) begin
                  flag_q     <= 1'b1;
                  hold_cnt_q <= '0;
                  rep_q      <= 1'b1;
               end else begin
                  hold_cnt_q <= hold_inc_d;
               end
`endif
            end

            REL_F: begin
`ifdef KEY_REPEAT_EN
               hold_cnt_q <= '0;
               rep_q      <= 1'b0;
`endif
               if (!key_s) begin
                  state_q <= DOWN;            // release glitch, no new pulse
               end else if (cnt_q == CNT_LIM) begin
                  state_q <= IDLE;
                  level_q <= 1'b0;
               end else begin
                  cnt_q <= cnt_inc_d;
               end
            end

            default: state_q <= IDLE;
         endcase
      end
   end

   assign key_if.key_flag  = flag_q;
   assign key_if.key_level = level_q;

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce with CNT_MAX=9, LONG_MAX=49, REPEAT_MAX=19.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
//
// Cycle numbering: "edge E" is the first rising edge that samples a new key_in
// value; an event caused at edge E+k is seen at the following falling edge with cyc == E+k.
module tb_key_debounce;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   key_debounce_if kif ();

   key_debounce #(
      .CNT_MAX    (9),
      .LONG_MAX   (49),
      .REPEAT_MAX (19)
   ) dut (
      .sys_clk   (clk),
      .sys_rst_n (rst_n),
      .key_if    (kif.slave)
   );

   typedef struct {
      int   cyc;
      logic lvl;
   } lvl_ev_t;

   int      cyc = 0;
   int      n_tests = 0;
   int      n_fail = 0;
   int      flag_cnt = 0;
   int      exp_flag_q[$];
   lvl_ev_t exp_lvl_q[$];
   logic    prev_lvl = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(string name, int act, int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cyc %0d)", name, act, exp, cyc);
      end
   endfunction

   // Monitor: every pulse and every level change must match the next expected entry.
   always @(negedge clk) begin
      if (rst_n) begin
         if (kif.key_flag) begin
            flag_cnt++;
            if (exp_flag_q.size() == 0) chk("flag_unexpected", cyc, -1);
            else                        chk("flag_cycle", cyc, exp_flag_q.pop_front());
         end
         if (kif.key_level !== prev_lvl) begin
            if (exp_lvl_q.size() == 0) begin
               chk("level_unexpected", cyc, -1);
            end else begin
               lvl_ev_t ev;
               ev = exp_lvl_q.pop_front();
               chk("level_cycle", cyc, ev.cyc);
               chk("level_value", int'(kif.key_level), int'(ev.lvl));
            end
            prev_lvl = kif.key_level;
         end
      end
   end

   task automatic tick(int n);
      repeat (n) @(negedge clk);
   endtask

   // Called at a falling edge; returns the index E of the edge that samples v.
   task automatic drive(logic v, output int e);
      kif.key_in = v;
      e = cyc + 1;
   endtask

   task automatic press_expect(output int e);
      drive(1'b0, e);
      exp_flag_q.push_back(e + 12);
      exp_lvl_q.push_back('{e + 12, 1'b1});
   endtask

   task automatic release_expect();
      int r;
      drive(1'b1, r);
      exp_lvl_q.push_back('{r + 12, 1'b0});
   endtask

   initial begin
      int e;
      int base;
      int exp_mode[3];
      exp_mode[0] = 2;
      exp_mode[1] = 3;
      exp_mode[2] = 1;

      kif.key_in = 1'b1;
      rst_n      = 1'b0;
      tick(3);
      chk("rst_flag",  int'(kif.key_flag),  0);
      chk("rst_level", int'(kif.key_level), 0);
      rst_n = 1'b1;
      tick(8);

      // 1: clean press held 30 cycles, then release
      press_expect(e);
      tick(30);
      release_expect();
      tick(25);

      // 2: toggling every 3 cycles never qualifies
      for (int k = 0; k < 14; k++) begin
         drive((k % 2 == 0) ? 1'b0 : 1'b1, e);
         tick(3);
      end
      drive(1'b1, e);
      tick(25);
      chk("toggle_level", int'(kif.key_level), 0);

      // 3: press, 5-cycle release glitch, final release
      press_expect(e);
      tick(20);
      drive(1'b1, e);
      tick(5);
      drive(1'b0, e);
      tick(20);
      release_expect();
      tick(25);

      // 4: reset while PRESS_F has cnt=5, key kept low after reset
      drive(1'b0, e);
      tick(8);
      rst_n = 1'b0;
      tick(1);
      chk("midrst_flag",  int'(kif.key_flag),  0);
      chk("midrst_level", int'(kif.key_level), 0);
      rst_n = 1'b1;
      tick(100);
      chk("held_rst_level", int'(kif.key_level), 0);
      drive(1'b1, e);
      tick(10);
      press_expect(e);
      tick(20);
      release_expect();
      tick(25);

      // 5: long hold of 120 cycles
      press_expect(e);
`ifdef KEY_REPEAT_EN
      exp_flag_q.push_back(e + 62);
      exp_flag_q.push_back(e + 82);
      exp_flag_q.push_back(e + 102);
`endif
      tick(120);
      release_expect();
      tick(25);

      // 6: three presses drive a 1->2->3->1 display mode
      base = flag_cnt;
      for (int p = 0; p < 3; p++) begin
         press_expect(e);
         tick(20);
         release_expect();
         tick(25);
         chk("vga_mode", ((flag_cnt - base) % 3) + 1, exp_mode[p]);
      end

      tick(5);
      chk("flag_left",  exp_flag_q.size(), 0);
      chk("level_left", exp_lvl_q.size(),  0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
